// File: rtl/uart_pkg.sv
// Shared types and constants for the UART byte transmitter.
// The frame state set includes PARITY; it is only reachable when UART_TX_PARITY_EN is defined.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1, pulses bit_done_o on the last
// cycle of a bit and wraps to 0 so the next bit starts aligned.
module uart_baud_counter #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic bit_done_o
);

  localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count_q;

  assign bit_done_o = (count_q == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would create order-dependent simulation races.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else if (clear_i || bit_done_o) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/uart_byte_transmitter.sv
// UART transmitter with a one-byte holding register ahead of the shifter; frames go
// out back-to-back. Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_byte_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] uart_tx,
  input  logic       tx_valid,
  output logic       uart_ready,
  output logic       tx_serial,
  output logic       tx_busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_byte_transmitter: CLKS_PER_BIT must be at least 2");
  end

  tx_state_t      state_q, state_d;
  logic [7:0]     hold_q, hold_d;
  logic           hold_full_q, hold_full_d;
  logic [7:0]     shift_q, shift_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
`ifdef UART_TX_PARITY_EN
  logic           parity_q, parity_d;
`endif

  logic bit_done;
  logic accept;
  logic load;

  uart_baud_counter #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_counter (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (state_q == IDLE),
    .bit_done_o(bit_done)
  );

  assign uart_ready = ~hold_full_q;
  assign accept     = tx_valid & ~hold_full_q;
  assign tx_busy    = (state_q != IDLE);

  // Accept needs an empty holding register and load needs a full one, so the two
  // updates to hold_full below can never apply at the same edge.
  // NOTE: every combinational output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    bit_idx_d   = bit_idx_q;
`ifdef UART_TX_PARITY_EN
    parity_d    = parity_q;
`endif
    load        = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_full_q) begin
          load    = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_done) begin
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          shift_d   = {1'b0, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_done) state_d = STOP;
      end
`endif
      STOP: begin
        if (bit_done) begin
          if (hold_full_q) begin
            load    = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_d    = ^hold_q;
`endif
    end

    if (accept) begin
      hold_d      = uart_tx;
      hold_full_d = 1'b1;
    end
  end

  // Decoded straight from state so reset forces the line high without waiting for a clock.
  always_comb begin
    tx_serial = 1'b1;
    case (state_q)
      START:  tx_serial = 1'b0;
      DATA:   tx_serial = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_serial = parity_q;
`endif
      default: tx_serial = 1'b1;
    endcase
  end

  // NOTE: the data registers are reset along with control so a reset mid-frame
  // discards both the in-flight and the held byte deterministically.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_idx_q   <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
`ifdef UART_TX_PARITY_EN
      parity_q    <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_byte_transmitter.sv
// Directed bench for uart_byte_transmitter at CLKS_PER_BIT=10; define UART_TX_PARITY_EN
// for both this file and the RTL to exercise the 11-bit frame.
module tb_uart_byte_transmitter;

  localparam int CPB = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] uart_tx = 8'h00;
  logic       tx_valid = 1'b0;
  logic       uart_ready;
  logic       tx_serial;
  logic       tx_busy;

  int tests_run = 0;
  int failures  = 0;

  uart_byte_transmitter #(
    .CLK_FREQ (1_000_000),
    .BAUD_RATE(100_000)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .uart_tx   (uart_tx),
    .tx_valid  (tx_valid),
    .uart_ready(uart_ready),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line level for frame bit k of byte b (start, 8 data LSB first, [parity], stop).
  function automatic logic exp_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
    if (k == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  // Checks frame cycles [first, last) starting at the current negedge sample.
  task automatic expect_frame(input logic [7:0] b, input int first, input int last);
    for (int i = first; i < last; i++) begin
      check($sformatf("frame_%02h_c%0d_serial", b, i), {7'd0, tx_serial}, {7'd0, exp_bit(b, i / CPB)});
      check($sformatf("frame_%02h_c%0d_busy", b, i), {7'd0, tx_busy}, 8'd1);
      @(negedge clk);
    end
  endtask

  task automatic expect_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_c%0d_serial", tag, i), {7'd0, tx_serial}, 8'd1);
      check($sformatf("%s_c%0d_busy", tag, i), {7'd0, tx_busy}, 8'd0);
      check($sformatf("%s_c%0d_ready", tag, i), {7'd0, uart_ready}, 8'd1);
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset held for two cycles, outputs checked while asserted.
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_serial", {7'd0, tx_serial}, 8'd1);
    check("rst_ready", {7'd0, uart_ready}, 8'd1);
    check("rst_busy", {7'd0, tx_busy}, 8'd0);
    rst = 1'b1;
    expect_idle("post_rst", 50);

    // Single byte 0x54.
    tx_valid = 1'b1; uart_tx = 8'h54;
    @(negedge clk);
    check("t2_ready_low", {7'd0, uart_ready}, 8'd0);
    check("t2_still_idle", {7'd0, tx_serial}, 8'd1);
    tx_valid = 1'b0; uart_tx = 8'h00;
    @(negedge clk);
    check("t2_ready_back", {7'd0, uart_ready}, 8'd1);
    expect_frame(8'h54, 0, FRAME);
    expect_idle("t2_after", 5);

    // Back-to-back 0x54 then 0x44, second offered as soon as ready returns.
    tx_valid = 1'b1; uart_tx = 8'h54;
    @(negedge clk);
    check("t3_ready_low", {7'd0, uart_ready}, 8'd0);
    tx_valid = 1'b0;
    @(negedge clk);
    check("t3_start0", {7'd0, tx_serial}, 8'd0);
    check("t3_ready_back", {7'd0, uart_ready}, 8'd1);
    tx_valid = 1'b1; uart_tx = 8'h44;
    @(negedge clk);
    check("t3_second_held", {7'd0, uart_ready}, 8'd0);
    tx_valid = 1'b0; uart_tx = 8'h00;
    expect_frame(8'h54, 1, FRAME);
    expect_frame(8'h44, 0, FRAME);
    expect_idle("t3_after", 5);

    // tx_valid held high with changing data; only accept-edge bytes go out.
    tx_valid = 1'b1; uart_tx = 8'h11;
    @(negedge clk);
    check("t4_ready_low_a", {7'd0, uart_ready}, 8'd0);
    uart_tx = 8'hFF;
    @(negedge clk);
    check("t4_start_a", {7'd0, tx_serial}, 8'd0);
    check("t4_ready_a", {7'd0, uart_ready}, 8'd1);
    uart_tx = 8'h22;
    @(negedge clk);
    check("t4_ready_low_b", {7'd0, uart_ready}, 8'd0);
    uart_tx = 8'hEE;
    expect_frame(8'h11, 1, FRAME);
    check("t4_start_b", {7'd0, tx_serial}, 8'd0);
    check("t4_ready_b", {7'd0, uart_ready}, 8'd1);
    uart_tx = 8'h33;
    @(negedge clk);
    check("t4_ready_low_c", {7'd0, uart_ready}, 8'd0);
    tx_valid = 1'b0; uart_tx = 8'h00;
    expect_frame(8'h22, 1, FRAME);
    expect_frame(8'h33, 0, FRAME);
    expect_idle("t4_after", 5);

    // Accept on the final stop cycle with hold empty: exactly one idle cycle.
    tx_valid = 1'b1; uart_tx = 8'h54;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    expect_frame(8'h54, 0, FRAME - 1);
    check("t6_last_stop", {7'd0, tx_serial}, 8'd1);
    check("t6_last_ready", {7'd0, uart_ready}, 8'd1);
    tx_valid = 1'b1; uart_tx = 8'h44;
    @(negedge clk);
    check("t6_gap_busy", {7'd0, tx_busy}, 8'd0);
    check("t6_gap_serial", {7'd0, tx_serial}, 8'd1);
    check("t6_gap_ready", {7'd0, uart_ready}, 8'd0);
    tx_valid = 1'b0; uart_tx = 8'h00;
    @(negedge clk);
    expect_frame(8'h44, 0, FRAME);
    expect_idle("t6_after", 5);

    // Reset at cycle 35 of a 0x54 frame with 0x99 held; both must be discarded.
    tx_valid = 1'b1; uart_tx = 8'h54;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    tx_valid = 1'b1; uart_tx = 8'h99;
    expect_frame(8'h54, 0, 1);
    tx_valid = 1'b0; uart_tx = 8'h00;
    check("t5_hold_full", {7'd0, uart_ready}, 8'd0);
    expect_frame(8'h54, 1, 35);
    rst = 1'b0;
    #1;
    check("t5_async_serial", {7'd0, tx_serial}, 8'd1);
    check("t5_async_ready", {7'd0, uart_ready}, 8'd1);
    check("t5_async_busy", {7'd0, tx_busy}, 8'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    tx_valid = 1'b1; uart_tx = 8'h44;
    @(negedge clk);
    check("t5_first_accept", {7'd0, uart_ready}, 8'd0);
    tx_valid = 1'b0; uart_tx = 8'h00;
    @(negedge clk);
    expect_frame(8'h44, 0, FRAME);
    expect_idle("t5_after", 10);

    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule

// File: doc/uart_byte_transmitter.md
Name: uart_byte_transmitter

Overview:
Serial UART transmitter that accepts bytes from the Crossbar_pipeline over the parallel uart_tx / uart_ready byte interface. It shifts each byte out as an 8N1 frame on a single TX line to the host.
- One-byte holding register in front of the shift register, so the crossbar can queue the next byte while the current frame is on the line.
- Frames go out back-to-back with no idle gap.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
BAUD_RATE, 9600, serial bit rate in baud
CLKS_PER_BIT, CLK_FREQ/BAUD_RATE (derived localparam), clock cycles per serial bit; elaboration error if < 2

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
uart_tx  input  8  byte to transmit, from crossbar
tx_valid  input  1  byte on uart_tx is valid
uart_ready  output  1  holding register empty; byte accepted at edge where tx_valid && uart_ready
tx_serial  output  1  serial line, idle high
tx_busy  output  1  a frame (start..stop) is currently on the line

Behaviour:
- Clock and reset: one clock domain (clk); rst asynchronous, active-low.
- Reset values:
  - tx_serial=1, uart_ready=1, tx_busy=0.
  - State IDLE; hold_full=0; bit and baud counters 0.
- Accept:
  - At edge N with tx_valid && uart_ready, uart_tx is latched into hold_reg; hold_full=1; uart_ready=0 after edge N.
  - tx_valid while uart_ready=0 is ignored; uart_tx is sampled only at accept.
- States: IDLE, START, DATA, STOP (PARITY added when the macro is defined).
- IDLE:
  - tx_serial=1, tx_busy=0.
  - At an edge with hold_full=1 (value before the edge): shifter<=hold_reg, hold_full<=0, go START.
  - Hence accept at edge N gives start bit low from edge N+1, and uart_ready high again from N+1.
- START: tx_serial=0 for CLKS_PER_BIT cycles, then DATA.
- DATA:
  - 8 bits, LSB first, CLKS_PER_BIT cycles each.
  - 3-bit bit index wraps 7->0 on exit to STOP.
- STOP:
  - tx_serial=1 for CLKS_PER_BIT cycles.
  - On the final stop cycle: if hold_full=1, reload the shifter and go directly to START (no idle cycle); else go IDLE.
- Timing:
  - tx_busy=1 in START/DATA/(PARITY)/STOP.
  - Frame length is exactly 10*CLKS_PER_BIT cycles (11* with parity).
  - Baud counter counts 0..CLKS_PER_BIT-1, resets on each state/bit change.
- Simultaneous events:
  - Accept on the final STOP cycle with hold empty: the transition uses the pre-edge hold_full=0, so the FSM goes IDLE. The load happens at the following edge, giving exactly 1 idle-high cycle.
  - Accept and shifter-load at the same edge (from the STOP reload or from IDLE) cannot collide, because accept requires hold_full=0 and load requires hold_full=1.
- Reset mid-frame: tx_serial goes high immediately (asynchronously); the in-flight and held bytes are discarded; uart_ready=1.
- Reset release: the first accept is possible at the first edge after release.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: PARITY state is inserted between DATA and STOP. It drives the even parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles; frame = 11*CLKS_PER_BIT.
- Undefined: PARITY state and logic are absent; 8N1, frame = 10*CLKS_PER_BIT.

Decomposition:
- Package uart_pkg:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
  - DATA_BITS=8 constant.
  - Function clks_per_bit(clk_freq, baud) used for the derived localparam.
- One natural sub-module: uart_baud_counter.
  - Per-bit cycle counter with clear input and bit_done pulse on count CLKS_PER_BIT-1.
  - The FSM, holding register and shifter live in the top.

Test Plan:
(All tests use CLK_FREQ=1_000_000, BAUD_RATE=100_000, so CLKS_PER_BIT=10.)
1. Reset held low 2 cycles, released -> tx_serial=1, uart_ready=1, tx_busy=0; no edge on tx_serial for 50 cycles.
2. Send 0x54 ('T') with 1-cycle tx_valid at edge N -> uart_ready low for 1 cycle; starting at N+1, tx_serial holds each of these bits for 10 cycles: 0 | 0,0,1,0,1,0,1,0 | 1. tx_busy high for 100 cycles.
3. 0x54 then 0x44 ('D'), offered immediately after uart_ready returns -> second frame starts on the cycle after the first stop bit ends, with no idle gap. Second data bits: 0,0,1,0,0,0,1,0.
4. Hold tx_valid high with changing uart_tx while uart_ready=0 -> only bytes present on accept edges are transmitted; no byte is duplicated or dropped.
5. Assert rst at cycle 35 of a 0x54 frame -> tx_serial=1 and uart_ready=1 immediately; after release, a new 0x44 frame transmits correctly.
6. UART_TX_PARITY_EN defined:
   - 0x54 -> parity bit 1 before stop, frame 110 cycles.
   - 0x44 -> parity bit 0.
